// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: fetches one word, holds it for the
// decoder until consumed, and follows redirects (misaligned targets halt with a sticky fault).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  Opcode,
    output logic        fault,
    output logic [1:0]  dbg_state
);
    // Handshake: a fetch transfer completes on any clock edge with imem_req && imem_ack;
    // the held word is consumed on any clock edge with instr_valid && !stall.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] drop_pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        drop_q;
    logic        fault_q;

    logic xfer;
    logic redir;
    logic misaligned;

    assign xfer       = (state_q == REQ) && imem_ack;
    // Once a fault is pending, later redirects are ignored.
    assign redir      = redirect && !fault_q;
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = (redir && misaligned) ? HALT : REQ;
            REQ: begin
                if (xfer) begin
                    if (redir)       state_d = misaligned ? HALT : REQ;
                    else if (fault_q) state_d = HALT;
                    else if (drop_q)  state_d = REQ;
                    else              state_d = HOLD;
                end
            end
            HOLD: begin
                if (redir)       state_d = misaligned ? HALT : REQ;
                else if (!stall) state_d = REQ;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == REQ);
        imem_addr   = pc_q;
        instr_valid = (state_q == HOLD);
        instr       = instr_q;
        instr_pc    = instr_pc_q;
        Opcode      = (state_q == HOLD) ? instr_q[6:0] : 7'b0000000;
        fault       = fault_q;
        dbg_state   = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            drop_pc_q  <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redir) begin
                        if (misaligned) fault_q <= 1'b1;
                        else            pc_q    <= redirect_pc;
                    end
                end
                REQ: begin
                    if (xfer) begin
                        drop_q <= 1'b0;
                        if (redir) begin
                            if (misaligned) fault_q <= 1'b1;
                            else            pc_q    <= redirect_pc;
                        end else if (drop_q) begin
                            if (!fault_q) pc_q <= drop_pc_q;
                        end else begin
                            instr_q    <= imem_rdata;
                            instr_pc_q <= pc_q;
                        end
                    end else if (redir) begin
                        // Address must stay stable until ack; remember where to go afterwards.
                        drop_q    <= 1'b1;
                        drop_pc_q <= redirect_pc;
                        if (misaligned) fault_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        if (misaligned) fault_q <= 1'b1;
                        else            pc_q    <= redirect_pc;
                    end else if (!stall) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, then randomized fetch/stall/redirect
// traffic checked by a scoreboard fed from a sequential-stream reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  Opcode;
    logic        fault;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    int consumes = 0;
    logic rand_phase = 1'b0;
    logic [63:0] exp_q[$];
    logic [31:0] gen_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .Opcode(Opcode), .fault(fault),
        .dbg_state(dbg_state)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_model();
        while (exp_q.size() < 8) begin
            exp_q.push_back({gen_pc, mem_word(gen_pc)});
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    // Scoreboard monitor: samples mid-cycle, when inputs for the next edge are settled.
    always @(negedge clk) begin
        if (rand_phase) begin
            logic [63:0] e;
            check("req_during_hold", {31'b0, imem_req && instr_valid}, 32'd0);
            if (!instr_valid) check("opcode_idle", {25'b0, Opcode}, 32'd0);
            if (instr_valid && !stall) begin
                consumes++;
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", instr_pc, e[63:32]);
                    check("sb_instr", instr, e[31:0]);
                    check("sb_opcode", {25'b0, Opcode}, {25'b0, e[6:0]});
                end
            end
        end
    end

    initial begin
        logic [31:0] tmp;
        // Reset values, with a stray ack that must be ignored.
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #3;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_opcode", {25'b0, Opcode}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        check("idle_req", {31'b0, imem_req}, 32'd0);
        tick();
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        imem_rdata = 32'h0000_0033;
        tick();
        check("first_valid", {31'b0, instr_valid}, 32'd1);
        check("first_opcode", {25'b0, Opcode}, 32'h33);
        check("first_instr_pc", instr_pc, 32'h0);
        imem_ack = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_instr", instr, 32'h33);
            check("stall_pc", instr_pc, 32'h0);
            check("stall_noreq", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("seq_req", {31'b0, imem_req}, 32'd1);
        check("seq_addr", imem_addr, 32'h4);
        // Redirect while a fetch is pending; ack arrives two cycles later.
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("drop_addr_hold1", imem_addr, 32'h4);
        tick();
        check("drop_addr_hold2", imem_addr, 32'h4);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("drop_novalid", {31'b0, instr_valid}, 32'd0);
        check("drop_new_addr", imem_addr, 32'h100);
        imem_rdata = 32'h0000_0013;
        tick();
        check("drop_instr", instr, 32'h13);
        check("drop_instr_pc", instr_pc, 32'h100);
        imem_ack = 1'b0;
        // Redirect in HOLD overrides stall.
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        check("hold_redir_valid", {31'b0, instr_valid}, 32'd0);
        check("hold_redir_addr", imem_addr, 32'h40);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_006F;
        tick();
        check("hold_redir_pc", instr_pc, 32'h40);
        imem_ack = 1'b0;
        // PC wrap at the top of the address space.
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0017;
        tick();
        check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        imem_ack = 1'b0;
        tick();
        check("wrap_next_addr", imem_addr, 32'h0);
        check("wrap_fault", {31'b0, fault}, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0;
        // Misaligned redirect from HOLD halts.
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        check("halt_fault", {31'b0, fault}, 32'd1);
        check("halt_state", {30'b0, dbg_state}, 32'd3);
        check("halt_valid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_noreq", {31'b0, imem_req}, 32'd0);
            check("halt_fault_sticky", {31'b0, fault}, 32'd1);
        end
        reset = 1'b1;
        #1;
        check("halt_rst_fault", {31'b0, fault}, 32'd0);
        check("halt_rst_addr", imem_addr, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("restart_req", {31'b0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        // Misaligned redirect during a pending fetch: request completes, then halts.
        redirect = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        check("mis_pending_req", {31'b0, imem_req}, 32'd1);
        check("mis_pending_fault", {31'b0, fault}, 32'd1);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("mis_done_noreq", {31'b0, imem_req}, 32'd0);
        check("mis_done_valid", {31'b0, instr_valid}, 32'd0);
        check("mis_done_state", {30'b0, dbg_state}, 32'd3);

        // Randomized phase.
        reset = 1'b1;
        tick();
        exp_q.delete();
        gen_pc = 32'h0;
        fill_model();
        reset = 1'b0;
        rand_phase = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            redirect = 1'b0;
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) begin
                tmp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : $urandom();
                redirect = 1'b1;
                stall = 1'b1;
                redirect_pc = {tmp[31:2], 2'b00};
                exp_q.delete();
                gen_pc = redirect_pc;
            end
            fill_model();
            imem_ack = imem_req && ($urandom_range(0, 2) != 0);
            imem_rdata = mem_word(imem_addr);
        end
        tick();
        rand_phase = 1'b0;
        check("progress", {31'b0, consumes >= 200}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
